// File: rtl/vram_pkg.sv
// Shared VRAM definitions used by the arbiter, LCD fetch and DMA blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vram_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;

  // Arbitration owner between CPU and DMA on contention cycles.
  typedef enum logic [1:0] {
    RR_CPU    = 2'd0,
    RR_DMA    = 2'd1,
    DMA_BURST = 2'd2
  } owner_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: LCD fetch has absolute priority, CPU/DMA share the rest round-robin with DMA bursting.
// Latency: grants are combinational (0 cycles); lcd_valid/cpu_ack/dma_ack and mem_rdata arrive one cycle after the grant.
// Backpressure: a losing CPU/DMA request stays held until granted; no bubbles. VRAM_ARB_BURST_CAP_EN caps DMA bursts at BURST_CAP.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W    = VRAM_ADDR_W,
  parameter int DATA_W    = VRAM_DATA_W,
  parameter int BURST_CAP = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              lcd_req,
  input  logic [ADDR_W-1:0] lcd_addr,
  output logic              lcd_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_last,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(BURST_CAP + 1);

  owner_e            owner;
  logic [CNT_W-1:0]  burst_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              cap_hit;
  logic              dma_pref;
  logic              cpu_win;
  logic              dma_win;

`ifdef VRAM_ARB_BURST_CAP_EN
  // A burst that has run BURST_CAP in-burst beats yields one contention cycle to the CPU.
  assign cap_hit = (owner == DMA_BURST) && (burst_cnt >= CNT_W'(BURST_CAP));
`else
  // Uncapped bursts: the counter is tracked but never revokes DMA priority.
  logic cnt_unused;
  assign cnt_unused = ^burst_cnt;
  assign cap_hit    = 1'b0;
`endif

  assign dma_pref = (owner == RR_DMA) || ((owner == DMA_BURST) && !cap_hit);

  // Pick the CPU/DMA winner; any LCD strobe blocks both.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (!lcd_req) begin
      if (cpu_req && dma_req) begin
        dma_win = dma_pref;
        cpu_win = !dma_pref;
      end else begin
        cpu_win = cpu_req;
        dma_win = dma_req;
      end
    end
  end

  assign cpu_gnt = cpu_win;
  assign dma_gnt = dma_win;

  // Steer the memory port from the winner; the address holds when nobody is served.
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = cpu_wdata;
    if (lcd_req) begin
      mem_addr = lcd_addr;
    end else if (cpu_win) begin
      mem_addr = cpu_addr;
      mem_we   = cpu_we;
    end else if (dma_win) begin
      mem_addr  = dma_addr;
      mem_we    = dma_we;
      mem_wdata = dma_wdata;
    end
  end

  // Remember the last driven address so an idle port does not toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else if (lcd_req || cpu_win || dma_win) begin
      addr_q <= mem_addr;
    end
  end

  // Owner update; LCD-only cycles leave it untouched so losers resume where they were.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner <= RR_CPU;
    end else if (cpu_win) begin
      owner <= RR_DMA;
    end else if (dma_win) begin
      owner <= dma_last ? RR_CPU : DMA_BURST;
    end else if ((owner == DMA_BURST) && !lcd_req && !dma_req) begin
      owner <= RR_CPU;
    end
  end

  // Count in-burst DMA beats; saturate so a long uncapped burst cannot wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt <= '0;
    end else if (cpu_win || (dma_win && dma_last)) begin
      burst_cnt <= '0;
    end else if (dma_win && (owner == DMA_BURST) && (burst_cnt != '1)) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

  // One-stage ack pipeline aligned with the synchronous-read VRAM data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
    end else begin
      lcd_valid <= lcd_req;
      cpu_ack   <= cpu_win;
      dma_ack   <= dma_win;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: model expects 0-cycle grants and 1-cycle acks/read data.
// Backpressure: stimulus holds CPU/DMA requests until granted; VRAM_ARB_BURST_CAP_EN selects the capped model.
module tb_vram_arbiter;

  localparam int AW  = vram_pkg::VRAM_ADDR_W;
  localparam int DW  = vram_pkg::VRAM_DATA_W;
  localparam int CAP = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          lcd_req = 1'b0;
  logic [AW-1:0] lcd_addr = '0;
  logic          lcd_valid;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt;
  logic          cpu_ack;
  logic          dma_req = 1'b0;
  logic          dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_last = 1'b0;
  logic          dma_gnt;
  logic          dma_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_CAP(CAP)) dut (
    .clk(clk), .reset_n(reset_n),
    .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_valid(lcd_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous-read VRAM behind the arbiter.
  logic [DW-1:0] vram [0:(1<<AW)-1] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: memory image, who was served last, and burst bookkeeping.
  logic [DW-1:0] m_mem [0:(1<<AW)-1] = '{default: 8'h00};
  bit            last_cpu;    // CPU was the most recent CPU/DMA winner
  bit            burst_open;  // a DMA burst has started and its last beat is not yet served
  int            burst_run;   // DMA beats served while a burst was open
  logic [AW-1:0] m_addr;
  bit            e_lcd_v, e_cpu_ack, e_dma_ack, e_cpu_rd, e_dma_rd;
  logic [DW-1:0] e_lcd_d, e_cpu_d, e_dma_d;
  bit            s_cpu_gnt, s_dma_gnt, s_lcd_valid;

  task automatic m_reset();
    last_cpu = 1'b0; burst_open = 1'b0; burst_run = 0; m_addr = '0;
    e_lcd_v = 1'b0; e_cpu_ack = 1'b0; e_dma_ack = 1'b0;
    s_cpu_gnt = 1'b0; s_dma_gnt = 1'b0; s_lcd_valid = 1'b0;
  endtask

  // Check one cycle at the falling edge, then advance the model and the clock.
  task automatic step();
    bit ec, ed, dpri, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    @(negedge clk);
    ec = 1'b0; ed = 1'b0; dpri = 1'b0;
    if (!lcd_req) begin
      if (cpu_req && dma_req) begin
`ifdef VRAM_ARB_BURST_CAP_EN
        dpri = burst_open ? (burst_run < CAP) : last_cpu;
`else
        dpri = burst_open ? 1'b1 : last_cpu;
`endif
        ed = dpri; ec = !dpri;
      end else begin
        ec = cpu_req; ed = dma_req;
      end
    end
    ea = m_addr; ewe = 1'b0; ewd = '0;
    if (lcd_req)  ea = lcd_addr;
    else if (ec) begin ea = cpu_addr; ewe = cpu_we; ewd = cpu_wdata; end
    else if (ed) begin ea = dma_addr; ewe = dma_we; ewd = dma_wdata; end

    chk("cpu_gnt",   32'(cpu_gnt),   32'(ec));
    chk("dma_gnt",   32'(dma_gnt),   32'(ed));
    chk("mem_we",    32'(mem_we),    32'(ewe));
    chk("mem_addr",  32'(mem_addr),  32'(ea));
    if (ewe) chk("mem_wdata", 32'(mem_wdata), 32'(ewd));
    chk("lcd_valid", 32'(lcd_valid), 32'(e_lcd_v));
    chk("cpu_ack",   32'(cpu_ack),   32'(e_cpu_ack));
    chk("dma_ack",   32'(dma_ack),   32'(e_dma_ack));
    if (e_lcd_v)              chk("lcd_rdata", 32'(mem_rdata), 32'(e_lcd_d));
    if (e_cpu_ack && e_cpu_rd) chk("cpu_rdata", 32'(mem_rdata), 32'(e_cpu_d));
    if (e_dma_ack && e_dma_rd) chk("dma_rdata", 32'(mem_rdata), 32'(e_dma_d));

    e_lcd_v   = lcd_req; e_lcd_d = m_mem[lcd_addr];
    e_cpu_ack = ec; e_cpu_rd = !cpu_we; e_cpu_d = m_mem[cpu_addr];
    e_dma_ack = ed; e_dma_rd = !dma_we; e_dma_d = m_mem[dma_addr];
    if (ewe) m_mem[ea] = ewd;
    if (lcd_req || ec || ed) m_addr = ea;
    if (ec) begin
      last_cpu = 1'b1; burst_open = 1'b0; burst_run = 0;
    end else if (ed) begin
      if (burst_open) burst_run++;
      last_cpu = 1'b0;
      if (dma_last) begin burst_open = 1'b0; burst_run = 0; end
      else burst_open = 1'b1;
    end else if (!lcd_req && !dma_req) begin
      burst_open = 1'b0;
    end
    s_cpu_gnt = cpu_gnt; s_dma_gnt = dma_gnt; s_lcd_valid = lcd_valid;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    lcd_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; dma_last = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [AW-1:0] raddr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 31));
    if ($urandom_range(0, 1) == 1) a = a | 13'h1FE0;
    return a;
  endfunction

  task automatic rand_phase(input int ncyc, input int pl, input int pc, input int pd, input int plast);
    for (int i = 0; i < ncyc; i++) begin
      lcd_req  = ($urandom_range(0, 99) < pl);
      lcd_addr = raddr();
      if (!cpu_req || s_cpu_gnt) begin
        cpu_req   = ($urandom_range(0, 99) < pc);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = raddr();
        cpu_wdata = DW'($urandom);
      end
      if (!dma_req || s_dma_gnt) begin
        if (dma_req && !dma_last) dma_req = ($urandom_range(0, 99) < 85);
        else                      dma_req = ($urandom_range(0, 99) < pd);
        dma_we    = 1'($urandom_range(0, 1));
        dma_addr  = raddr();
        dma_wdata = DW'($urandom);
        dma_last  = ($urandom_range(0, 99) < plast);
      end
      step();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int beats, dma_before, lcd_cnt, lv_cnt;
    bit cpu_seen;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lcd_valid", 32'(lcd_valid), 32'd0);
    chk("rst_cpu_ack",   32'(cpu_ack),   32'd0);
    chk("rst_dma_ack",   32'(dma_ack),   32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // CPU and DMA both always requesting single beats: CPU first, then alternate.
    cpu_req = 1'b1; cpu_we = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cpu_addr = AW'(i); dma_addr = AW'(16 + i);
      step();
      chk("alt_cpu", 32'(s_cpu_gnt), 32'(i % 2 == 0));
      chk("alt_dma", 32'(s_dma_gnt), 32'(i % 2 == 1));
    end
    idle(2);

    // CPU write then single read of 0x0123.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_wdata = 8'h5A;
    step();
    cpu_we = 1'b0;
    step();
    idle(2);

    // LCD and CPU write to 0x1FFF in the same cycle: LCD first, CPU next.
    lcd_req = 1'b1; lcd_addr = 13'h0040;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 8'hA5;
    step();
    lcd_req = 1'b0;
    step();
    cpu_req = 1'b0;
    idle(2);

    // 20-beat DMA burst with the CPU waiting from the second cycle.
    dma_req = 1'b1; dma_we = 1'b1; dma_last = 1'b0; dma_addr = 13'h0100; dma_wdata = 8'h10;
    beats = 0; dma_before = 0; cpu_seen = 1'b0;
    for (int i = 0; i < 80 && (beats < 20 || !cpu_seen); i++) begin
      step();
      if (s_dma_gnt) begin beats++; dma_addr = dma_addr + 1'b1; dma_wdata = DW'(beats); end
      if (s_cpu_gnt) begin cpu_seen = 1'b1; dma_before = beats; cpu_req = 1'b0; end
      if (i == 0 && !cpu_seen) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0105; end
      dma_req  = (beats < 20);
      dma_last = (beats == 19);
    end
    chk("burst_beats", 32'(beats), 32'd20);
    chk("burst_cpu_served", 32'(cpu_seen), 32'd1);
`ifdef VRAM_ARB_BURST_CAP_EN
    chk("burst_cap_wait", 32'(dma_before <= CAP + 1), 32'd1);
`else
    chk("burst_nocap_wait", 32'(dma_before), 32'd20);
`endif
    idle(2);

    // LCD strobe every 4th cycle during a 12-beat DMA read burst.
    dma_req = 1'b1; dma_we = 1'b0; dma_last = 1'b0; dma_addr = 13'h0100;
    beats = 0; lcd_cnt = 0; lv_cnt = 0;
    for (int i = 0; i < 40 && beats < 12; i++) begin
      lcd_req  = (i % 4 == 0);
      lcd_addr = AW'(13'h0800 + i);
      if (lcd_req) lcd_cnt++;
      step();
      if (s_lcd_valid) lv_cnt++;
      if (s_dma_gnt) begin beats++; dma_addr = dma_addr + 1'b1; end
      dma_req  = (beats < 12);
      dma_last = (beats == 11);
    end
    lcd_req = 1'b0; dma_req = 1'b0;
    step();
    if (s_lcd_valid) lv_cnt++;
    chk("lcd_burst_beats", 32'(beats), 32'd12);
    chk("lcd_valid_count", 32'(lv_cnt), 32'(lcd_cnt));
    idle(2);

    // Reset in the cycle after a CPU read grant drops the ack and restores CPU preference.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    step();
    cpu_req = 1'b0; reset_n = 1'b0;
    #1;
    chk("midrst_cpu_ack",  32'(cpu_ack),  32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_reset();
    cpu_req = 1'b1; dma_req = 1'b1; dma_last = 1'b1; dma_we = 1'b0; dma_addr = 13'h0007;
    step();
    chk("midrst_cpu_first", 32'(s_cpu_gnt), 32'd1);
    idle(2);

    rand_phase(600, 20, 50, 50, 30);
    rand_phase(600, 0, 90, 90, 10);
    rand_phase(600, 40, 30, 70, 20);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
